sha512_msg_padder: RTL and testbench
====================================

// Module: sha512_msg_padder
// PURPOSE
//  Converts the 512-bit cache lines streamed by the read engine (S_RD_FETCH/S_RD_WAIT path)
//  into padded 1024-bit SHA-512 message blocks for the SHA-512 compression core.
//  Applies FIPS 180-4 padding: 0x80 byte, zero fill, 128-bit big-endian bit length.
//  One message per start pulse; the length comes from t_hc_buffer.size (bytes).
// PARAMETERS
//  LEN_W   32  width of msg_len (bytes); bit length = msg_len*8, upper bits of 128-bit field are 0
//  BLK_CW  28  width of blk_count (blocks emitted for current message)
// PORTS
//  clk         in   1     clock (CCI-P pClk domain)
//  rst_n       in   1     asynchronous active-low reset
//  start       in   1     1-cycle pulse: begin new message; ignored while busy
//  msg_len     in   LEN_W message length in bytes, sampled on accepted start
//  in_valid    in   1     cache line valid (t_block)
//  in_data     in   512   cache line; message byte k of line at in_data[8k+7:8k]
//  in_ready    out  1     padder accepts in_data this cycle
//  blk_valid   out  1     padded block valid
//  blk_data    out  1024  block; message byte i at blk_data[1023-8i -: 8] (SHA big-endian)
//  blk_last    out  1     qualifies blk_valid: final block of message
//  blk_ready   in   1     core accepts block
//  busy        out  1     message in progress
//  done        out  1     1-cycle pulse after final block handshake
//  blk_count   out  BLK_CW blocks handed off for current message
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, block register and counters cleared.
//  States: S_IDLE -> (start) S_LOAD -> S_OUT -> S_LOAD | S_DONE -> S_IDLE.
//  S_IDLE: latch len=msg_len, base=0, half=0, blk_count=0; busy=1 from next cycle.
//  S_LOAD: fills half h (0/1) of block; off = base + 64*h.
//   - off < len: in_ready=1; on in_valid&in_ready write line; bytes with off+k >= len forced 0;
//     if len in [off, off+63], byte (len-off) = 8'h80. Stall (no change) while !in_valid.
//   - off >= len: no line consumed, in_ready=0; half = zeros, plus 8'h80 at byte 0 iff off==len.
//     Completes in one cycle.
//   - After half 1: if base+111 >= len (final block) bytes 112..127 = {len*8} big-endian,
//     128-bit, zero-extended; go S_OUT.
//  S_OUT: blk_valid=1, blk_last=final flag; blk_data/blk_last stable until blk_ready.
//   On handshake: blk_count++, base+=128; final -> S_DONE else S_LOAD half=0.
//  S_DONE: done=1 one cycle, busy=0 next cycle, -> S_IDLE.
//  Lines consumed = ceil(len/64); blocks = floor((len+16)/128)+1. in_ready never 1 outside S_LOAD.
//  Latency: blk_valid asserts the cycle after the half-1 fill completes; max 1 half per cycle.
//  Byte arithmetic in LEN_W+1 bits to avoid wrap at len near 2^LEN_W; len=0 legal (1 block, no lines).
//  Surplus bytes of the last line are discarded, never carried into the next message.
//  start during busy: ignored, no effect on len. rst_n low mid-message: immediate abort, all cleared;
//  the read engine is reset alongside, so partially delivered lines are not replayed.
// TESTING
//  1 len=0 -> no in_ready; 1 block: [1023:1016]=8'h80, rest 0, low128=0, blk_last=1, done pulse.
//  2 len=3, line[23:0]=24'h636261 -> 1 line, 1 block [1023:992]=32'h61626380, low128=128'h18, last.
//  3 len=112, 2 lines (line2 bytes 48..63 = 8'hFF) -> blk0 byte112=8'h80, bytes 113..127=0, not last;
//    blk1 all 0 except low128=128'h380, last; garbage masked.
//  4 len=128 -> 2 lines; blk0 = data only, blk1 byte0=8'h80, low128=128'h400, blk_count=2.
//  5 len=200, blk_ready low 5 cycles, in_valid gaps -> blk_data stable, in_ready=0 in S_OUT,
//    4 lines consumed, 2 blocks, no data lost/duplicated.
//  6 rst_n low mid-block of len=300 -> outputs 0 asynchronously; new start len=3 gives test-2 result.

Source files
------------

// File: rtl/sha512_msg_padder.sv
// sha512_msg_padder: packs 512-bit cache lines into FIPS 180-4 padded 1024-bit SHA-512 blocks
module sha512_msg_padder #(
    parameter int LEN_W  = 32,
    parameter int BLK_CW = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic              in_valid,
    input  logic [511:0]      in_data,
    output logic              in_ready,
    output logic              blk_valid,
    output logic [1023:0]     blk_data,
    output logic              blk_last,
    input  logic              blk_ready,
    output logic              busy,
    output logic              done,
    output logic [BLK_CW-1:0] blk_count
);
    localparam int W1 = LEN_W + 1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT, S_DONE} state_t;
    state_t state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [W1-1:0] base, off, len_x;
    logic half, fin, final_blk, adv, has_data;
    logic [511:0] half_line;
    logic [127:0] bit_len;
    logic [1023:0] blk;
    always_comb begin
        len_x     = {1'b0, len};
        off       = base + (half ? W1'(64) : W1'(0));
        has_data  = off < len_x;
        final_blk = base + W1'(111) >= len_x;
        adv       = state == S_LOAD && (!has_data || in_valid);
        bit_len   = {{(128-LEN_W-3){1'b0}}, len, 3'b000};
        half_line = '0;
        // bytes past the message end are masked; the byte at the end position carries the 0x80 marker
        for (int k = 0; k < 64; k++)
            half_line[511-8*k -: 8] = (off + W1'(k)) < len_x ? in_data[8*k +: 8] :
                                      (off + W1'(k)) == len_x ? 8'h80 : 8'h00;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = state == S_IDLE ? (start ? S_LOAD : S_IDLE) :
                    state == S_LOAD ? (adv && half ? S_OUT : S_LOAD) :
                    state == S_OUT  ? (blk_ready ? (fin ? S_DONE : S_LOAD) : S_OUT) : S_IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else state <= state_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            base      <= '0;
            half      <= 1'b0;
            fin       <= 1'b0;
            blk       <= '0;
            blk_count <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                len       <= msg_len;
                base      <= '0;
                half      <= 1'b0;
                fin       <= 1'b0;
                blk_count <= '0;
            end
            if (adv && !half) begin
                blk[1023:512] <= half_line;
                half          <= 1'b1;
            end
            if (adv && half) begin
                blk[511:0] <= final_blk ? {half_line[511:128], bit_len} : half_line;
                fin        <= final_blk;
            end
            if (state == S_OUT && blk_ready) begin
                blk_count <= blk_count + BLK_CW'(1);
                base      <= base + W1'(128);
                half      <= 1'b0;
            end
        end
    end
    assign in_ready  = state == S_LOAD && has_data;
    assign blk_valid = state == S_OUT;
    assign blk_last  = blk_valid && fin;
    assign blk_data  = blk;
    assign busy      = state != S_IDLE;
    assign done      = state == S_DONE;
endmodule

// File: tb/tb_sha512_msg_padder.sv
// tb_sha512_msg_padder: directed padding vectors, backpressure, and async abort checks
module tb_sha512_msg_padder;
    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, blk_ready = 1;
    logic [31:0] msg_len = '0;
    logic [511:0] in_data = '0;
    logic in_ready, blk_valid, blk_last, busy, done;
    logic [1023:0] blk_data;
    logic [27:0] blk_count;
    logic [1023:0] blk_cap [0:3];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    sha512_msg_padder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_last(blk_last),
        .blk_ready(blk_ready), .busy(busy), .done(done), .blk_count(blk_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int i);
        return 8'(8'h61 + i % 26);
    endfunction

    // line j of the message; bytes past the end are 0xFF garbage that must be masked
    function automatic logic [511:0] make_line(input int j, input int len);
        logic [511:0] l;
        for (int k = 0; k < 64; k++)
            l[8*k +: 8] = (64*j + k < len) ? msg_byte(64*j + k) : 8'hFF;
        return l;
    endfunction

    function automatic logic [1023:0] exp_block(input int b, input int len);
        logic [1023:0] e;
        logic [127:0] lv;
        int total, p;
        total = ((len + 16) / 128 + 1) * 128;
        lv = 128'(len) << 3;
        for (int i = 0; i < 128; i++) begin
            p = b*128 + i;
            e[1023-8*i -: 8] = p < len ? msg_byte(p) : p == len ? 8'h80 :
                               p >= total - 16 ? 8'(lv >> (8*(total - 1 - p))) : 8'h00;
        end
        return e;
    endfunction

    task automatic run_msg(input string name, input int len, input bit gaps, input int stall);
        int nblk, nlines, lines, blks, cyc, sc;
        bit fin, have;
        logic [1023:0] held, eb;
        nblk = (len + 16) / 128 + 1;
        nlines = (len + 63) / 64;
        lines = 0; blks = 0; cyc = 0; sc = 0; fin = 0; have = 0; held = '0;
        for (int i = 0; i < 4; i++) blk_cap[i] = '1;
        @(negedge clk); start = 1; msg_len = len;
        @(negedge clk); start = 0;
        while (!fin && cyc < 3000) begin
            in_valid = gaps ? (cyc % 3 != 1) : 1'b1;
            in_data = make_line(lines, len);
            blk_ready = !(blks == 0 && sc < stall);
            #1;
            if (in_valid && in_ready) lines++;
            if (blk_valid) begin
                check({name, " in_ready in S_OUT"}, 128'(in_ready), 0);
                if (!blk_ready) begin
                    if (have) check({name, " blk stable"}, 128'(blk_data == held), 1);
                    held = blk_data; have = 1; sc++;
                end else begin
                    eb = exp_block(blks, len);
                    for (int c = 0; c < 8; c++)
                        check($sformatf("%s blk%0d chunk%0d", name, blks, c), blk_data[128*c +: 128], eb[128*c +: 128]);
                    check({name, " blk_last"}, 128'(blk_last), 128'(blks == nblk - 1));
                    if (blks < 4) blk_cap[blks] = blk_data;
                    blks++; have = 0;
                end
            end
            if (done) fin = 1;
            @(negedge clk); cyc++;
        end
        in_valid = 0; blk_ready = 1;
        check({name, " done seen"}, 128'(fin), 1);
        check({name, " lines"}, 128'(lines), 128'(nlines));
        check({name, " blocks"}, 128'(blks), 128'(nblk));
        check({name, " blk_count"}, 128'(blk_count), 128'(nblk));
        check({name, " busy after done"}, 128'(busy), 0);
    endtask

    initial begin
        int j;
        #2;
        check("reset busy", 128'(busy), 0);
        check("reset blk_valid", 128'(blk_valid), 0);
        check("reset in_ready", 128'(in_ready), 0);
        check("reset blk_data", 128'(|blk_data), 0);
        @(negedge clk); rst_n = 1;

        run_msg("t1", 0, 0, 0);
        check("t1 byte0", 128'(blk_cap[0][1023:1016]), 128'h80);
        check("t1 rest", 128'(|blk_cap[0][1015:0]), 0);

        run_msg("t2", 3, 0, 0);
        check("t2 head", 128'(blk_cap[0][1023:992]), 128'h61626380);
        check("t2 len", blk_cap[0][127:0], 128'h18);

        run_msg("t3", 112, 0, 0);
        check("t3 byte112", 128'(blk_cap[0][127:120]), 128'h80);
        check("t3 bytes113+", blk_cap[0][119:0], 0);
        check("t3 blk1 zero", 128'(|blk_cap[1][1023:128]), 0);
        check("t3 blk1 len", blk_cap[1][127:0], 128'h380);

        run_msg("t4", 128, 0, 0);
        check("t4 blk0 byte0", 128'(blk_cap[0][1023:1016]), 128'h61);
        check("t4 blk1 byte0", 128'(blk_cap[1][1023:1016]), 128'h80);
        check("t4 blk1 len", blk_cap[1][127:0], 128'h400);

        run_msg("t5", 200, 1, 5);

        // abort a len=300 message mid-block with no clock edge involved
        @(negedge clk); start = 1; msg_len = 300;
        @(negedge clk); start = 0; j = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1; in_data = make_line(j, 300); blk_ready = 1;
            #1; if (in_ready) j++;
            @(negedge clk);
        end
        check("t6 busy before abort", 128'(busy), 1);
        #2 rst_n = 0;
        #1;
        check("t6 busy", 128'(busy), 0);
        check("t6 in_ready", 128'(in_ready), 0);
        check("t6 blk_valid", 128'(blk_valid), 0);
        check("t6 blk_count", 128'(blk_count), 0);
        check("t6 blk_data", 128'(|blk_data), 0);
        in_valid = 0;
        @(negedge clk); rst_n = 1;
        run_msg("t6 rerun", 3, 0, 0);
        check("t6 head", 128'(blk_cap[0][1023:992]), 128'h61626380);
        check("t6 len", blk_cap[0][127:0], 128'h18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
